// File: rtl/calc_pkg.sv
// Shared calculator definitions: encoder FSM states, sign nibble codes,
// BCD digit count and the coded-word field layout (also used by the
// input-side decoder).
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        NEGATE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] SIGN_NEG = 4'b1111;
    localparam logic [3:0] SIGN_POS = 4'b0000;

    // Three digits cover every magnitude up to 2^(W-1) for W <= 9.
    localparam int BCD_DIGITS = 3;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    // Coded word: {sign, hundreds, tens, units}
    localparam int SIGN_LSB     = 12;
    localparam int HUNDREDS_LSB = 8;
    localparam int TENS_LSB     = 4;
    localparam int UNITS_LSB    = 0;

    // Assemble the 16-bit coded word from a sign nibble and three BCD digits.
    function automatic logic [15:0] pack_word(input logic [3:0] sign_code,
                                              input logic [BCD_W-1:0] digits);
        logic [15:0] word;
        word = '0;
        word[SIGN_LSB     +: 4] = sign_code;
        word[HUNDREDS_LSB +: 4] = digits[11:8];
        word[TENS_LSB     +: 4] = digits[7:4];
        word[UNITS_LSB    +: 4] = digits[3:0];
        return word;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decade.
module bcd_add3_digit (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/result_sign_mag_encoder.sv
// Converts the ALU's signed two's-complement result into a sign nibble plus
// three BCD magnitude digits, using a multi-cycle double-dabble FSM with a
// start/finish handshake toward the display stage.
module result_sign_mag_encoder
    import calc_pkg::*;
#(
    parameter int         W        = 8,
    parameter logic [3:0] SIGN_NEG = calc_pkg::SIGN_NEG,
    parameter logic [3:0] SIGN_POS = calc_pkg::SIGN_POS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] result,
    input  logic         encode_sel,
    input  logic         wr_enable,
    output logic [15:0]  nr_coded_out,
    output logic         busy,
    output logic         encode_finish
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    state_t             state;
    logic [W-1:0]       res_reg;
    logic               sign_reg;
    logic [W-1:0]       mag_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_reg;

    // One add-3 corrector per BCD digit, applied before every shift.
    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_add3
            bcd_add3_digit u_add3 (
                .digit    (bcd_reg[gi*4 +: 4]),
                .adjusted (bcd_adj[gi*4 +: 4])
            );
        end
    endgenerate

    // Handshake FSM with registered outputs; the word is only updated in DONE,
    // so an aborted conversion never leaks a partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            res_reg       <= '0;
            sign_reg      <= 1'b0;
            mag_reg       <= '0;
            bcd_reg       <= '0;
            cnt_reg       <= '0;
            nr_coded_out  <= 16'h0000;
            busy          <= 1'b0;
            encode_finish <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (encode_sel && wr_enable) begin
                        res_reg       <= result;
                        sign_reg      <= result[W-1];
                        busy          <= 1'b1;
                        encode_finish <= 1'b0;
                        state         <= NEGATE;
                    end
                end
                NEGATE: begin
                    // Unsigned W-bit negate: -2^(W-1) maps to 2^(W-1) with no overflow.
                    mag_reg <= sign_reg ? (~res_reg + W'(1)) : res_reg;
                    bcd_reg <= '0;
                    cnt_reg <= '0;
                    state   <= CONVERT;
                end
                CONVERT: begin
                    {bcd_reg, mag_reg} <= {bcd_adj, mag_reg} << 1;
                    cnt_reg            <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(W-1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    nr_coded_out  <= pack_word(sign_reg ? SIGN_NEG : SIGN_POS, bcd_reg);
                    encode_finish <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
